// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port 64-bit RAM shared by instruction-fetch and data ports
//
// Purpose:
//   Arbitrates the core's 32-bit read-only fetch port and 64-bit read/write
//   data port onto one single-port RAM with fixed read latency RD_LAT.
//   Exactly one transaction is outstanding at a time. Data has priority, but
//   after MAX_D_STREAK consecutive data grants made while fetch waits, fetch
//   wins the next grant.
//
// Ports:
//   clk, reset_n                 clock (rising edge), asynchronous active-low reset
//   i_req/i_addr                 fetch request (level) and byte address
//   i_gnt/i_rvalid/i_rdata       fetch accept, response pulse, instruction word
//   d_req/d_wen/d_addr/d_wdata   data request (level), write flag, address, write data
//   d_gnt/d_rvalid/d_rdata       data accept, response pulse (read data or write ack)
//   ram_en/ram_wen/ram_addr      RAM strobe, write enable, 8-byte aligned address
//   ram_wdata/ram_rdata          RAM write data, read data (valid RD_LAT after ram_en)

module mem_port_arbiter #(
  parameter int RD_LAT       = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        ram_en,
  output logic        ram_wen,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  input  logic [63:0] ram_rdata
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] CNT_LOAD   = 3'(RD_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] streak;
  logic       owner_d;   // 1: outstanding transaction belongs to the data port
  logic       addr2;     // which 32-bit half of the RAM word the fetch wants

  logic resp_cycle;
  logic accept;
  logic fetch_forced;
  logic grant_d;
  logic grant_i;

  // Low address bits select nothing inside a 64-bit RAM word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[2:0]};

  // The response cycle doubles as an accept cycle, so a new grant can overlap
  // the previous rvalid and throughput reaches one transaction per RD_LAT.
  // reset_n gates everything so outputs are quiet for the whole reset.
  assign resp_cycle   = reset_n && (state == WAIT) && (cnt == 3'd0);
  assign accept       = reset_n && ((state == IDLE) || resp_cycle);
  assign fetch_forced = i_req && (streak == STREAK_MAX);
  assign grant_d      = accept && d_req && !fetch_forced;
  assign grant_i      = accept && i_req && !grant_d;

  assign i_gnt     = grant_i;
  assign d_gnt     = grant_d;
  assign ram_en    = grant_i || grant_d;
  assign ram_wen   = grant_d && d_wen;
  assign ram_addr  = grant_d ? {d_addr[63:3], 3'b000} :
                     grant_i ? {i_addr[63:3], 3'b000} : 64'h0;
  assign ram_wdata = grant_d ? d_wdata : 64'h0;

  assign i_rvalid = resp_cycle && !owner_d;
  assign d_rvalid = resp_cycle && owner_d;
  assign i_rdata  = i_rvalid ? (addr2 ? ram_rdata[63:32] : ram_rdata[31:0]) : 32'h0;
  assign d_rdata  = d_rvalid ? ram_rdata : 64'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      streak  <= 4'd0;
      owner_d <= 1'b0;
      addr2   <= 1'b0;
    end else begin
      if (grant_i || grant_d) begin
        state   <= WAIT;
        cnt     <= CNT_LOAD;
        owner_d <= grant_d;
        addr2   <= i_addr[2];
        // Streak only counts data grants that made a waiting fetch wait longer.
        if (grant_i || !i_req) begin
          streak <= 4'd0;
        end else if (streak != STREAK_MAX) begin
          streak <= streak + 4'd1;
        end
      end else if (state == WAIT) begin
        if (cnt != 3'd0) begin
          cnt <= cnt - 3'd1;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [63:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_wen, d_gnt, d_rvalid;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        ram_en, ram_wen;
  logic [63:0] ram_addr, ram_wdata, ram_rdata;

  logic        b_i_req, b_i_gnt, b_i_rvalid;
  logic [63:0] b_i_addr;
  logic [31:0] b_i_rdata;
  logic        b_d_req, b_d_wen, b_d_gnt, b_d_rvalid;
  logic [63:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic        b_ram_en, b_ram_wen;
  logic [63:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.RD_LAT(LAT), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(.RD_LAT(1), .MAX_D_STREAK(MAXS)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_wen(b_d_wen), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .ram_en(b_ram_en), .ram_wen(b_ram_wen), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // Contents of never-written RAM words.
  function automatic logic [63:0] init_word(input logic [63:0] a);
    if (a == 64'h1000) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  // RAM behind the RD_LAT=2 arbiter.
  logic [63:0] ram_mem [8192];
  bit          ram_wr  [8192];
  logic [63:0] pipe    [LAT];

  always @(posedge clk) begin
    if (ram_en && ram_wen) begin
      ram_mem[ram_addr[15:3]] <= ram_wdata;
      ram_wr[ram_addr[15:3]]  <= 1'b1;
    end
    if (ram_en && !ram_wen)
      pipe[0] <= ram_wr[ram_addr[15:3]] ? ram_mem[ram_addr[15:3]] : init_word(ram_addr);
    else
      pipe[0] <= 64'h0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[LAT-1];

  // Read-only RAM behind the RD_LAT=1 arbiter.
  always @(posedge clk) b_ram_rdata <= b_ram_en ? init_word(b_ram_addr) : 64'h0;

  // Reference memory maintained by the model.
  logic [63:0] sh_mem [8192];
  bit          sh_wr  [8192];

  function automatic logic [63:0] shadow_rd(input logic [63:0] a);
    return sh_wr[a[15:3]] ? sh_mem[a[15:3]] : init_word({a[63:3], 3'b000});
  endfunction

  typedef struct {
    int          due;
    bit          is_d;
    bit          wr;
    logic [63:0] data;
  } resp_t;

  task automatic test_reset();
    reset_n = 1'b0;
    i_req = 1'b1; i_addr = 64'h1004;
    d_req = 1'b1; d_wen = 1'b1; d_addr = 64'h80; d_wdata = 64'h55;
    b_i_req = 1'b0; b_i_addr = 64'h0; b_d_req = 1'b1; b_d_wen = 1'b0;
    b_d_addr = 64'h100; b_d_wdata = 64'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, ram_en, ram_wen} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, ram_en, ram_wen});
    end
    checks++;
    if (i_rdata !== 32'h0 || d_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata);
    end
    checks++;
    if (b_d_gnt !== 1'b0 || b_ram_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_b_strobes: got gnt=%b en=%b want 0", b_d_gnt, b_ram_en);
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0; b_d_req = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got en=%b ig=%b dg=%b want 0", ram_en, i_gnt, d_gnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    i_req = 1'b1; i_addr = 64'h1004;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt: got ig=%b dg=%b want 1 0", i_gnt, d_gnt);
    end
    checks++;
    if (ram_en !== 1'b1 || ram_wen !== 1'b0 || ram_addr !== 64'h1000) begin
      errors++;
      $display("FAIL fetch_ram: got en=%b wen=%b addr=%h want 1 0 1000", ram_en, ram_wen, ram_addr);
    end
    @(posedge clk); #1;
    i_req = 1'b0; i_addr = 64'hFFFF_0000;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      checks++;
      if (i_rvalid !== (k == LAT) || d_rvalid !== 1'b0 || ram_en !== 1'b0) begin
        errors++;
        $display("FAIL fetch_latency k=%0d: got iv=%b dv=%b en=%b want %0d 0 0", k, i_rvalid, d_rvalid, ram_en, k == LAT);
      end
      if (k == LAT) begin
        checks++;
        if (i_rdata !== 32'hAAAABBBB) begin
          errors++;
          $display("FAIL fetch_rdata: got %h want aaaabbbb", i_rdata);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_data_write();
    d_req = 1'b1; d_wen = 1'b1; d_addr = 64'h80; d_wdata = 64'h1122334455667788;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || ram_en !== 1'b1 || ram_wen !== 1'b1) begin
      errors++;
      $display("FAIL write_gnt: got dg=%b ig=%b en=%b wen=%b want 1 0 1 1", d_gnt, i_gnt, ram_en, ram_wen);
    end
    checks++;
    if (ram_addr !== 64'h80 || ram_wdata !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL write_payload: got addr=%h data=%h want 80 1122334455667788", ram_addr, ram_wdata);
    end
    sh_mem[13'h10] = 64'h1122334455667788;
    sh_wr[13'h10]  = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b0; d_wen = 1'b0; d_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      checks++;
      if (d_rvalid !== (k == LAT) || i_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL write_ack k=%0d: got dv=%b iv=%b want %0d 0", k, d_rvalid, i_rvalid, k == LAT);
      end
      @(posedge clk); #1;
    end
    d_req = 1'b1; d_wen = 1'b0; d_addr = 64'h87;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || ram_addr !== 64'h80 || ram_wen !== 1'b0) begin
      errors++;
      $display("FAIL readback_gnt: got dg=%b addr=%h wen=%b want 1 80 0", d_gnt, ram_addr, ram_wen);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == LAT) begin
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 64'h1122334455667788) begin
          errors++;
          $display("FAIL readback_data: got dv=%b data=%h want 1 1122334455667788", d_rvalid, d_rdata);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority_streak();
    logic [63:0] w;
    bit exp_d, prev_d;
    w = init_word(64'h2000);
    i_req = 1'b1; i_addr = 64'h2000; d_req = 1'b1; d_wen = 1'b0; d_addr = 64'h3000;
    for (int k = 0; k < 10 * LAT; k++) begin
      @(negedge clk);
      if (k % LAT == 0) begin
        exp_d = ((k / LAT) % (MAXS + 1)) != MAXS;
        checks++;
        if (d_gnt !== exp_d || i_gnt !== !exp_d) begin
          errors++;
          $display("FAIL streak_order slot=%0d: got dg=%b ig=%b want %b %b", k / LAT, d_gnt, i_gnt, exp_d, !exp_d);
        end
      end else begin
        checks++;
        if (d_gnt !== 1'b0 || i_gnt !== 1'b0) begin
          errors++;
          $display("FAIL streak_spacing k=%0d: got dg=%b ig=%b want 0 0", k, d_gnt, i_gnt);
        end
      end
      if (k > 0 && k % LAT == 0) begin
        prev_d = (((k / LAT) - 1) % (MAXS + 1)) != MAXS;
        checks++;
        if (d_rvalid !== prev_d || i_rvalid !== !prev_d) begin
          errors++;
          $display("FAIL streak_rvalid k=%0d: got dv=%b iv=%b want %b %b", k, d_rvalid, i_rvalid, prev_d, !prev_d);
        end
      end
      @(posedge clk); #1;
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== w[31:0]) begin
      errors++;
      $display("FAIL streak_last_fetch: got iv=%b dv=%b data=%h want 1 0 %h", i_rvalid, d_rvalid, i_rdata, w[31:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_withdraw();
    bit [8:0] acc_m  = 9'b111110011;
    bit [8:0] wait_m = 9'b111111101;
    bit exp_i;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 64'h400; i_addr = 64'h404;
    for (int s = 0; s < 9; s++) begin
      i_req = acc_m[s];
      @(negedge clk);
      exp_i = (s == 8);
      checks++;
      if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
        errors++;
        $display("FAIL withdraw_slot=%0d: got ig=%b dg=%b want %b %b", s, i_gnt, d_gnt, exp_i, !exp_i);
      end
      @(posedge clk); #1;
      i_req = wait_m[s];
      for (int k = 1; k < LAT; k++) begin
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
          errors++;
          $display("FAIL withdraw_inflight s=%0d: got ig=%b dg=%b want 0 0", s, i_gnt, d_gnt);
        end
        @(posedge clk); #1;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] prev;
    prev = 64'h0;
    b_d_req = 1'b1; b_d_wen = 1'b0; b_d_addr = 64'h100;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (b_d_gnt !== 1'b1 || b_ram_en !== 1'b1 || b_ram_addr !== b_d_addr) begin
        errors++;
        $display("FAIL b2b_gnt k=%0d: got dg=%b en=%b addr=%h want 1 1 %h", k, b_d_gnt, b_ram_en, b_ram_addr, b_d_addr);
      end
      checks++;
      if (k == 0) begin
        if (b_d_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_first_rvalid: got %b want 0", b_d_rvalid);
        end
      end else if (b_d_rvalid !== 1'b1 || b_d_rdata !== init_word(prev)) begin
        errors++;
        $display("FAIL b2b_rvalid k=%0d: got dv=%b data=%h want 1 %h", k, b_d_rvalid, b_d_rdata, init_word(prev));
      end
      prev = b_d_addr;
      @(posedge clk); #1;
      b_d_addr = b_d_addr + 64'h8;
    end
    b_d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (b_d_rvalid !== 1'b1 || b_d_rdata !== init_word(prev) || b_ram_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail: got dv=%b data=%h en=%b want 1 %h 0", b_d_rvalid, b_d_rdata, b_ram_en, init_word(prev));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_flight();
    i_req = 1'b1; i_addr = 64'h1004;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_gnt: got %b want 1", i_gnt);
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b1; d_wen = 1'b0; d_addr = 64'h40;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, ram_en, ram_wen} !== 6'b0 || i_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_inflight_outputs: got %b rdata=%h want 000000 0", {i_gnt, d_gnt, i_rvalid, d_rvalid, ram_en, ram_wen}, i_rdata);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; d_req = 1'b0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      checks++;
      if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_dropped k=%0d: got iv=%b dv=%b want 0 0", k, i_rvalid, d_rvalid);
      end
      @(posedge clk); #1;
    end
    i_req = 1'b1; i_addr = 64'h1000;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1 || ram_addr !== 64'h1000) begin
      errors++;
      $display("FAIL rst_after_gnt: got ig=%b addr=%h want 1 1000", i_gnt, ram_addr);
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      checks++;
      if (i_rvalid !== (k == LAT) || (k == LAT && i_rdata !== 32'hCCCCDDDD)) begin
        errors++;
        $display("FAIL rst_after_resp k=%0d: got iv=%b data=%h want %0d ccccdddd", k, i_rvalid, i_rdata, k == LAT);
      end
      @(posedge clk); #1;
    end
    // Reset landing mid-way through a response cycle must kill it at once.
    i_req = 1'b1; i_addr = 64'h1004;
    @(posedge clk); #1;
    i_req = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got iv=%b want 1", i_rvalid);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got iv=%b data=%h want 0 0", i_rvalid, i_rdata);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int n);
    bit ip, dp, dw, quiet, ei, ed, ev_i, ev_d;
    logic [63:0] ia, da, dwd, w;
    int free_at, streak;
    resp_t rq[$];
    resp_t r;
    ip = 0; dp = 0; dw = 0; ia = 0; da = 0; dwd = 0;
    free_at = 0; streak = 0;
    for (int t = 0; t < n + LAT + 2; t++) begin
      quiet = (t >= n);
      if (quiet) ip = 0;
      else if (ip && ($urandom % 10 == 0)) ip = 0;
      else if (!ip && ($urandom % 3 == 0)) begin
        ip = 1; ia = 64'($urandom_range(0, 511));
      end
      if (quiet) dp = 0;
      else if (dp && ($urandom % 10 == 0)) dp = 0;
      else if (!dp && ($urandom % 2 == 0)) begin
        dp = 1; dw = ($urandom % 3 == 0); da = 64'($urandom_range(0, 511));
        dwd = {$urandom, $urandom};
      end
      i_req = ip; i_addr = ia; d_req = dp; d_wen = dw; d_addr = da; d_wdata = dwd;
      @(negedge clk);
      ev_i = 0; ev_d = 0;
      if (rq.size() > 0 && rq[0].due == t) begin
        r = rq.pop_front();
        ev_d = r.is_d; ev_i = !r.is_d;
      end
      checks++;
      if (i_rvalid !== ev_i || d_rvalid !== ev_d) begin
        errors++;
        $display("FAIL rnd_rvalid t=%0d: got iv=%b dv=%b want %b %b", t, i_rvalid, d_rvalid, ev_i, ev_d);
      end
      if (ev_i) begin
        checks++;
        if (i_rdata !== r.data[31:0]) begin
          errors++;
          $display("FAIL rnd_i_rdata t=%0d: got %h want %h", t, i_rdata, r.data[31:0]);
        end
      end
      if (ev_d && !r.wr) begin
        checks++;
        if (d_rdata !== r.data) begin
          errors++;
          $display("FAIL rnd_d_rdata t=%0d: got %h want %h", t, d_rdata, r.data);
        end
      end
      ed = (t >= free_at) && dp && !(ip && streak == MAXS);
      ei = (t >= free_at) && ip && !ed;
      checks++;
      if (i_gnt !== ei || d_gnt !== ed) begin
        errors++;
        $display("FAIL rnd_gnt t=%0d: got ig=%b dg=%b want %b %b streak=%0d", t, i_gnt, d_gnt, ei, ed, streak);
      end
      checks++;
      if (ei || ed) begin
        if (ram_en !== 1'b1 || ram_wen !== (ed && dw) || ram_addr !== ((ed ? da : ia) & ~64'h7) ||
            (ed && dw && ram_wdata !== dwd)) begin
          errors++;
          $display("FAIL rnd_ram t=%0d: got en=%b wen=%b addr=%h wd=%h want 1 %b %h %h", t, ram_en, ram_wen,
                   ram_addr, ram_wdata, ed && dw, (ed ? da : ia) & ~64'h7, dwd);
        end
      end else if (ram_en !== 1'b0) begin
        errors++;
        $display("FAIL rnd_ram_idle t=%0d: got en=%b want 0", t, ram_en);
      end
      if (ed) begin
        r.due = t + LAT; r.is_d = 1; r.wr = dw;
        if (dw) begin
          sh_mem[da[15:3]] = dwd; sh_wr[da[15:3]] = 1'b1; r.data = dwd;
        end else begin
          r.data = shadow_rd(da);
        end
        rq.push_back(r);
        streak = ip ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        free_at = t + LAT;
        dp = 0; da = {$urandom, $urandom};
      end else if (ei) begin
        w = shadow_rd(ia);
        r.due = t + LAT; r.is_d = 0; r.wr = 0;
        r.data = {32'h0, ia[2] ? w[63:32] : w[31:0]};
        rq.push_back(r);
        streak = 0;
        free_at = t + LAT;
        ip = 0; ia = {$urandom, $urandom};
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain: got %0d outstanding want 0", rq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_priority_streak();
    test_withdraw();
    test_back_to_back();
    test_reset_in_flight();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
